// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// A fetch_entry_t pairs a returned instruction word with the PC it was fetched from.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [3:0]  MARK_WORD        = 4'hF;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Redirect targets are forced to word alignment.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with enqueue, dequeue and a single-cycle flush.
// Flush takes priority over any enqueue or dequeue in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               enq,
    input  fetch_entry_t       enq_data,
    input  logic               deq,
    output fetch_entry_t       head,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_deq;

    assign empty  = (count == '0);
    assign do_deq = deq && !empty;
    assign head   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(do_deq);
        end
    end

    always_ff @(posedge clock) begin
        if (reset && !flush && enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    // Upstream credit accounting must never let an enqueue land on a full buffer.
    assert property (@(posedge clock) disable iff (!reset)
        !(enq && !flush && !do_deq && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues one word read per cycle, buffers returned words
// with their PC and presents them to decode; redirects flush buffered and in-flight fetches.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] io_inst_addr,
    output logic        io_inst_readEn,
    output logic        io_inst_writeEn,
    output logic [31:0] io_inst_writeData,
    output logic [3:0]  io_inst_mark,
    input  logic [31:0] io_inst_readData,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [31:0]      pc;
    logic [31:0]      req_pc;
    logic             inflight;
    logic             issue;
    logic             deq;
    logic             enq;
    logic             kill;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [OCC_W-1:0] occupancy;
    fetch_entry_t     enq_entry;
    fetch_entry_t     head;

    // Decode handshake: out_valid says out_pc/out_inst hold a fetched instruction;
    // a transfer happens on a cycle where out_valid && out_ready, and the presented
    // entry stays stable until that transfer or a redirect.
    assign out_valid = reset && !fifo_empty;
    assign deq       = out_valid && out_ready;
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;

    // Credit counts buffered words plus the outstanding read, minus the slot freed this cycle.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(deq);
    assign issue     = reset && !redirect_valid && (occupancy < OCC_W'(FIFO_DEPTH));

    assign kill      = redirect_valid;
    assign enq       = reset && inflight && !kill;
    assign enq_entry = '{pc: req_pc, inst: io_inst_readData};

    assign io_inst_addr      = reset ? pc : RESET_PC;
    assign io_inst_readEn    = issue;
    assign io_inst_writeEn   = 1'b0;
    assign io_inst_writeData = 32'h0;
    assign io_inst_mark      = MARK_WORD;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= align_pc(redirect_pc);
            inflight <= 1'b0;
        end else if (issue) begin
            pc       <= pc + PC_STEP;
            req_pc   <= pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (redirect_valid),
        .enq      (enq),
        .enq_data (enq_entry),
        .deq      (deq),
        .head     (head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: memory model returns addr ^ A5A5_A5A5 one cycle after readEn.
module tb_inst_fetch_unit;

    localparam logic [31:0] K      = 32'hA5A5_A5A5;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] io_inst_addr;
    logic        io_inst_readEn;
    logic        io_inst_writeEn;
    logic [31:0] io_inst_writeData;
    logic [3:0]  io_inst_mark;
    logic [31:0] io_inst_readData;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int checks;
    int failures;
    logic [31:0] exp_q[$];
    logic [31:0] got_pc_q[$];
    logic [31:0] got_inst_q[$];

    inst_fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .io_inst_addr      (io_inst_addr),
        .io_inst_readEn    (io_inst_readEn),
        .io_inst_writeEn   (io_inst_writeEn),
        .io_inst_writeData (io_inst_writeData),
        .io_inst_mark      (io_inst_mark),
        .io_inst_readData  (io_inst_readData),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_inst          (out_inst)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (io_inst_readEn) io_inst_readData <= io_inst_addr ^ K;
    end

    // driver tasks
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic apply_reset(input logic ready);
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = ready;
        tick();
        tick();
    endtask

    task automatic collect(input int n, input int budget);
        got_pc_q.delete();
        got_inst_q.delete();
        for (int c = 0; c < budget && got_pc_q.size() < n; c++) begin
            if (out_valid && out_ready) begin
                got_pc_q.push_back(out_pc);
                got_inst_q.push_back(out_inst);
            end
            if (got_pc_q.size() < n) tick();
        end
    endtask

    // scoreboard: compare collected stream against exp_q
    task automatic score(input string name);
        checks++;
        if (got_pc_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got_pc_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_pc_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_pc_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_pc[%0d] got=%h exp=%h", name, i, got_pc_q[i], exp_q[i]);
            end
            checks++;
            if (got_inst_q[i] !== (exp_q[i] ^ K)) begin
                failures++;
                $display("FAIL %s_inst[%0d] got=%h exp=%h", name, i, got_inst_q[i], exp_q[i] ^ K);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        checks++;
        if (io_inst_readEn !== 1'b0) begin failures++; $display("FAIL rst_read_en got=%b exp=0", io_inst_readEn); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (io_inst_addr !== RST_PC) begin failures++; $display("FAIL rst_addr got=%h exp=%h", io_inst_addr, RST_PC); end
        checks++;
        if (io_inst_writeEn !== 1'b0) begin failures++; $display("FAIL rst_write_en got=%b exp=0", io_inst_writeEn); end
        checks++;
        if (io_inst_mark !== 4'hF) begin failures++; $display("FAIL rst_mark got=%h exp=f", io_inst_mark); end
    endtask

    task automatic test_stream();
        logic [31:0] ea;
        logic [31:0] ep;
        tick();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            ea = RST_PC + 32'(4 * k);
            checks++;
            if (io_inst_readEn !== 1'b1) begin failures++; $display("FAIL stream_read_en c%0d got=%b exp=1", k, io_inst_readEn); end
            checks++;
            if (io_inst_addr !== ea) begin failures++; $display("FAIL stream_addr c%0d got=%h exp=%h", k, io_inst_addr, ea); end
            if (k >= 2) begin
                ep = RST_PC + 32'(4 * (k - 2));
                checks++;
                if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid c%0d got=%b exp=1", k, out_valid); end
                checks++;
                if (out_pc !== ep) begin failures++; $display("FAIL stream_pc c%0d got=%h exp=%h", k, out_pc, ep); end
                checks++;
                if (out_inst !== (ep ^ K)) begin failures++; $display("FAIL stream_inst c%0d got=%h exp=%h", k, out_inst, ep ^ K); end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_valid c%0d got=%b exp=0", k, out_valid); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int issued;
        apply_reset(1'b0);
        tick();
        reset = 1'b1;
        #1;
        issued = 0;
        for (int c = 0; c < 10; c++) begin
            if (io_inst_readEn) issued++;
            if (c >= 2) begin
                checks++;
                if (io_inst_readEn !== 1'b0) begin failures++; $display("FAIL bp_read_en c%0d got=%b exp=0", c, io_inst_readEn); end
            end
            tick();
        end
        checks++;
        if (issued !== 2) begin failures++; $display("FAIL bp_issued got=%0d exp=2", issued); end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== RST_PC) begin
            failures++; $display("FAIL bp_head got=%b/%h exp=1/%h", out_valid, out_pc, RST_PC);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (io_inst_readEn !== 1'b1 || io_inst_addr !== RST_PC + 32'h8) begin
            failures++; $display("FAIL bp_resume got=%b/%h exp=1/%h", io_inst_readEn, io_inst_addr, RST_PC + 32'h8);
        end
        exp_q = '{RST_PC, RST_PC + 32'h4, RST_PC + 32'h8, RST_PC + 32'hC};
        collect(4, 12);
        score("bp_drain");
    endtask

    // Fill the buffer, free one slot for one cycle so a fetch of RST_PC+8 is in flight.
    task automatic fill_with_inflight();
        apply_reset(1'b0);
        tick();
        reset = 1'b1;
        repeat (6) tick();
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_pc !== RST_PC || io_inst_addr !== RST_PC + 32'h8 || io_inst_readEn !== 1'b1) begin
            failures++; $display("FAIL fill_state got=%h/%h/%b exp=%h/%h/1", out_pc, io_inst_addr, io_inst_readEn, RST_PC, RST_PC + 32'h8);
        end
        tick();
    endtask

    task automatic test_redirect_full();
        fill_with_inflight();
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0103;
        #1;
        checks++;
        if (io_inst_readEn !== 1'b0) begin failures++; $display("FAIL rd_full_read_en got=%b exp=0", io_inst_readEn); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (io_inst_readEn !== 1'b1 || io_inst_addr !== 32'h8000_0100) begin
            failures++; $display("FAIL rd_full_first got=%b/%h exp=1/80000100", io_inst_readEn, io_inst_addr);
        end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_full_flush c1 got=%b exp=0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_full_flush c2 got=%b exp=0", out_valid); end
        out_ready = 1'b1;
        exp_q = '{32'h8000_0100, 32'h8000_0104, 32'h8000_0108};
        collect(3, 10);
        score("rd_full");
    endtask

    task automatic test_back_to_back();
        apply_reset(1'b1);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        checks++;
        if (io_inst_readEn !== 1'b0) begin failures++; $display("FAIL b2b_read_en r0 got=%b exp=0", io_inst_readEn); end
        tick();
        redirect_pc = 32'h0000_0200;
        #1;
        checks++;
        if (io_inst_readEn !== 1'b0) begin failures++; $display("FAIL b2b_read_en r1 got=%b exp=0", io_inst_readEn); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (io_inst_readEn !== 1'b1 || io_inst_addr !== 32'h0000_0200) begin
            failures++; $display("FAIL b2b_first got=%b/%h exp=1/00000200", io_inst_readEn, io_inst_addr);
        end
        exp_q = '{32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
        collect(3, 10);
        score("b2b");
    endtask

    task automatic test_wrap();
        apply_reset(1'b1);
        tick();
        reset = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        #1;
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        collect(4, 12);
        score("wrap");
    endtask

    task automatic test_reset_mid();
        fill_with_inflight();
        out_ready = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || io_inst_readEn !== 1'b0 || io_inst_addr !== RST_PC) begin
            failures++; $display("FAIL mid_rst_state got=%b/%b/%h exp=0/0/%h", out_valid, io_inst_readEn, io_inst_addr, RST_PC);
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid c1 got=%b exp=0", out_valid); end
        checks++;
        if (io_inst_readEn !== 1'b1 || io_inst_addr !== RST_PC) begin
            failures++; $display("FAIL mid_rst_restart got=%b/%h exp=1/%h", io_inst_readEn, io_inst_addr, RST_PC);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid c2 got=%b exp=0", out_valid); end
        out_ready = 1'b1;
        exp_q = '{RST_PC, RST_PC + 32'h4, RST_PC + 32'h8};
        collect(3, 10);
        score("mid_rst");
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (io_inst_writeEn !== 1'b0 || io_inst_writeData !== 32'h0 || io_inst_mark !== 4'hF) begin
                failures++; $display("FAIL tied c%0d got=%b/%h/%h exp=0/0/f", c, io_inst_writeEn, io_inst_writeData, io_inst_mark);
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b0;
        io_inst_readData = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

endmodule
